// File: rtl/colour_pkg.sv
// colour_pkg: shared definitions for the colour sequencer.
//   FRAME_CNT_W          width of the frame counters and of the phase output
//   FLIP_FRAMES_DEF      default number of frames between alternate pulses
//   SCHEME_FRAMES_DEF    default number of frames between automatic scheme changes
//   seq_state_e          sequencer state encoding
package colour_pkg;

    localparam int FRAME_CNT_W       = 10;
    localparam int FLIP_FRAMES_DEF   = 30;
    localparam int SCHEME_FRAMES_DEF = 600;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } seq_state_e;

endpackage

// File: rtl/frame_divider.sv
// frame_divider: modulo-N frame counter with a registered wrap pulse.
//   clk    in   clock
//   reset  in   asynchronous reset, active low
//   en     in   advance the count (one frame)
//   clr    in   synchronous clear; wins over en and suppresses the wrap pulse
//   cnt    out  current count, 0..N-1
//   wrap   out  one-cycle pulse in the cycle after the count wraps to 0
module frame_divider
    import colour_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   clr,
    output logic [FRAME_CNT_W-1:0] cnt,
    output logic                   wrap
);

    localparam logic [FRAME_CNT_W-1:0] LAST = FRAME_CNT_W'(N - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clr) begin
                cnt <= '0;
            end else if (en) begin
                if (cnt == LAST) begin
                    cnt  <= '0;
                    wrap <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/colour_sequencer.sv
// colour_sequencer: schedules background flips and colour scheme changes on
// frame boundaries, plus a level-up request/acknowledge handshake.
//   clk             in   pixel clock
//   reset           in   asynchronous reset, active low
//   frame_start     in   one-cycle pulse at start of vertical blanking
//   running         in   game active level
//   level_up_req    in   held high until acknowledged
//   level_up_ack    out  one-cycle acknowledge
//   alternate       out  one-cycle background flip pulse
//   change_colours  out  one-cycle new-scheme pulse
//   phase           out  flip counter value
//
// state | meaning
// IDLE  | game stopped, counters held at 0, waiting for a frame while running
// START | next frame issues the opening scheme change (and services a request)
// RUN   | counting frames, periodic flips and scheme changes
module colour_sequencer
    import colour_pkg::*;
#(
    parameter int FLIP_FRAMES   = FLIP_FRAMES_DEF,
    parameter int SCHEME_FRAMES = SCHEME_FRAMES_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic                   running,
    input  logic                   level_up_req,
    output logic                   level_up_ack,
    output logic                   alternate,
    output logic                   change_colours,
    output logic [FRAME_CNT_W-1:0] phase
);

    seq_state_e state_q, state_d;
    logic       pending_q, pending_d;
    logic       ack_q, ack_d;
    logic       chg_q, chg_d;
    logic       cnt_en, cnt_clr, scheme_force;
    logic       flip_wrap, scheme_wrap;
    logic [FRAME_CNT_W-1:0] flip_cnt, scheme_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            chg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            chg_q     <= chg_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ack_d        = 1'b0;
        chg_d        = 1'b0;
        cnt_en       = 1'b0;
        cnt_clr      = 1'b0;
        scheme_force = 1'b0;
        if (!running) begin
            // Stopping wins over a coincident frame: no pulses for it.
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_clr = 1'b1;
                    if (frame_start) state_d = ST_START;
                end
                ST_START: begin
                    cnt_clr = 1'b1;
                    if (frame_start) begin
                        chg_d   = 1'b1;
                        ack_d   = pending_q;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (frame_start) begin
                        cnt_en = 1'b1;
                        if (pending_q) begin
                            // Restart the scheme period from this frame; a
                            // coincident wrap merges into this single pulse.
                            chg_d        = 1'b1;
                            ack_d        = 1'b1;
                            scheme_force = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    // The ack cycle masks req so a held request is not re-registered; req
    // still high one cycle later counts as a new request.
    always_comb begin
        if (ack_d) pending_d = 1'b0;
        else       pending_d = pending_q | (level_up_req & ~ack_q);
    end

    frame_divider #(.N(FLIP_FRAMES)) u_flip (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .cnt   (flip_cnt),
        .wrap  (flip_wrap)
    );

    frame_divider #(.N(SCHEME_FRAMES)) u_scheme (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .clr   (cnt_clr | scheme_force),
        .cnt   (scheme_cnt),
        .wrap  (scheme_wrap)
    );

    assign level_up_ack   = ack_q;
    assign alternate      = flip_wrap;
    assign change_colours = chg_q | scheme_wrap;
    assign phase          = flip_cnt;

    logic unused_scheme_cnt;
    assign unused_scheme_cnt = ^scheme_cnt;

endmodule

// File: tb/tb_colour_sequencer.sv
module tb_colour_sequencer;

    localparam int F = 4;
    localparam int S = 10;

    logic clk = 0, reset = 0, frame_start = 0, running = 0, level_up_req = 0;
    wire        level_up_ack, alternate, change_colours;
    wire [9:0]  phase;

    colour_sequencer #(.FLIP_FRAMES(F), .SCHEME_FRAMES(S)) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_start    (frame_start),
        .running        (running),
        .level_up_req   (level_up_req),
        .level_up_ack   (level_up_ack),
        .alternate      (alternate),
        .change_colours (change_colours),
        .phase          (phase)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0;
    wire  [12:0] obs = {level_up_ack, alternate, change_colours, phase};
    logic [12:0] exp_vec = '0;

    // Reference model: frames counted since the game started running.
    bit m_armed, m_inrun, m_pend;
    int m_rf, m_base;

    task automatic model_clear();
        m_armed = 0; m_inrun = 0; m_pend = 0; m_rf = 0; m_base = 0;
        exp_vec = '0;
    endtask

    task automatic tick();
        logic a, al, ch, pn;
        a = 0; al = 0; ch = 0;
        if (!running) begin
            m_armed = 0; m_inrun = 0; m_rf = 0; m_base = 0;
        end else if (frame_start) begin
            if (!m_armed && !m_inrun) begin
                m_armed = 1;
            end else if (m_armed) begin
                ch = 1; a = m_pend;
                m_armed = 0; m_inrun = 1; m_rf = 0; m_base = 0;
            end else begin
                m_rf++;
                al = (m_rf % F) == 0;
                ch = ((m_rf - m_base) % S) == 0;
                if (m_pend) begin ch = 1; a = 1; m_base = m_rf; end
            end
        end
        pn = a ? 1'b0 : (m_pend | (level_up_req & ~exp_vec[12]));
        m_pend = pn;
        exp_vec = {a, al, ch, (m_inrun ? 10'(m_rf % F) : 10'd0)};
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 0; frame_start = 0; level_up_req = 0;
        model_clear();
        @(negedge clk); @(negedge clk);
        reset = 1;
    endtask

    task automatic test_reset();
        reset = 0; running = 1; frame_start = 1; level_up_req = 1;
        model_clear();
        #1;
        total++; if (obs !== 13'd0) $display("FAIL reset_init got %h want 0", obs); else passed++;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total++; if (obs !== 13'd0) $display("FAIL reset_held got %h want 0", obs); else passed++;
        end
        frame_start = 0; level_up_req = 0;
        @(negedge clk); reset = 1;
    endtask

    task automatic test_start();
        int nchg = 0, nalt = 0;
        logic [9:0] ph [3];
        do_reset(); running = 1;
        for (int f = 0; f < 3; f++)
            for (int c = 0; c < 3; c++) begin
                frame_start = (c == 0);
                tick();
                if (c == 0) ph[f] = phase;
                nchg += change_colours; nalt += alternate;
                total++; if (obs !== exp_vec) $display("FAIL start f%0d c%0d got %h want %h", f, c, obs, exp_vec); else passed++;
            end
        total++; if (nchg !== 1 || nalt !== 0) $display("FAIL start_counts got chg=%0d alt=%0d want 1 0", nchg, nalt); else passed++;
        total++; if (ph[0] !== 0 || ph[1] !== 0 || ph[2] !== 1) $display("FAIL start_phase got %0d,%0d,%0d want 0,0,1", ph[0], ph[1], ph[2]); else passed++;
    endtask

    task automatic test_periodic();
        int nchg = 0, nalt = 0;
        do_reset(); running = 1;
        for (int f = 0; f < 27; f++)
            for (int c = 0; c < 3; c++) begin
                frame_start = (c == 0);
                tick();
                nchg += change_colours; nalt += alternate;
                total++; if (obs !== exp_vec) $display("FAIL periodic f%0d c%0d got %h want %h", f, c, obs, exp_vec); else passed++;
            end
        total++; if (nalt !== 6 || nchg !== 3) $display("FAIL periodic_counts got alt=%0d chg=%0d want 6 3", nalt, nchg); else passed++;
    endtask

    // run_frame k: frame index in RUN (frame 0 = arm, 1 = start, k+1 = RUN k)
    task automatic test_level_up(input int req_frame, input string name, output bit chg_at [0:24], output int nack);
        nack = 0;
        for (int k = 0; k < 25; k++) chg_at[k] = 0;
        do_reset(); running = 1;
        for (int f = 0; f < 24; f++)
            for (int c = 0; c < 4; c++) begin
                frame_start = (c == 0);
                if (f == req_frame + 1 && c == 2) level_up_req = 1;
                tick();
                if (level_up_ack) level_up_req = 0;
                if (f >= 2 && change_colours) chg_at[f - 1] = 1;
                nack += level_up_ack;
                total++; if (obs !== exp_vec) $display("FAIL %s f%0d c%0d got %h want %h", name, f, c, obs, exp_vec); else passed++;
            end
    endtask

    task automatic test_level_up_mid();
        bit chg_at [0:24]; int nack;
        test_level_up(3, "levelup", chg_at, nack);
        total++; if (!(chg_at[4] && chg_at[14] && !chg_at[10] && nack == 1))
            $display("FAIL levelup_sched got f4=%0d f10=%0d f14=%0d ack=%0d want 1 0 1 1", chg_at[4], chg_at[10], chg_at[14], nack);
        else passed++;
    endtask

    task automatic test_wrap_coincident();
        bit chg_at [0:24]; int nack;
        test_level_up(9, "wrapreq", chg_at, nack);
        total++; if (!(chg_at[10] && chg_at[20] && nack == 1))
            $display("FAIL wrapreq_sched got f10=%0d f20=%0d ack=%0d want 1 1 1", chg_at[10], chg_at[20], nack);
        else passed++;
    endtask

    task automatic test_running_drop();
        do_reset(); running = 1;
        for (int f = 0; f < 4; f++)
            for (int c = 0; c < 3; c++) begin
                frame_start = (c == 0);
                tick();
                total++; if (obs !== exp_vec) $display("FAIL drop_pre f%0d got %h want %h", f, obs, exp_vec); else passed++;
            end
        frame_start = 1; running = 0;
        tick();
        total++; if (obs !== 13'd0) $display("FAIL drop_coincident got %h want 0", obs); else passed++;
        frame_start = 0; level_up_req = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++; if (obs !== exp_vec) $display("FAIL drop_idle c%0d got %h want %h", c, obs, exp_vec); else passed++;
        end
        running = 1;
        for (int f = 0; f < 3; f++)
            for (int c = 0; c < 3; c++) begin
                frame_start = (c == 0);
                tick();
                if (f == 1 && c == 0) begin
                    total++; if (!(level_up_ack && change_colours)) $display("FAIL drop_start_ack got ack=%0b chg=%0b want 1 1", level_up_ack, change_colours); else passed++;
                end
                if (level_up_ack) level_up_req = 0;
                total++; if (obs !== exp_vec) $display("FAIL drop_restart f%0d c%0d got %h want %h", f, c, obs, exp_vec); else passed++;
            end
    endtask

    task automatic test_reset_pending();
        int nack = 0;
        do_reset(); running = 1;
        for (int f = 0; f < 6; f++)
            for (int c = 0; c < 3; c++) begin
                frame_start = (c == 0);
                level_up_req = (f == 5);
                tick();
                if (f < 5 || c == 0) begin
                    total++; if (obs !== exp_vec) $display("FAIL rstpend f%0d c%0d got %h want %h", f, c, obs, exp_vec); else passed++;
                end
                if (f == 5) break;
            end
        // RUN frame 4 just produced an alternate pulse; request now pending.
        #2 reset = 0;
        #1;
        total++; if (obs !== 13'd0) $display("FAIL rstpend_async got %h want 0", obs); else passed++;
        model_clear();
        level_up_req = 0; frame_start = 0;
        @(negedge clk); reset = 1;
        for (int f = 0; f < 5; f++)
            for (int c = 0; c < 3; c++) begin
                frame_start = (c == 0);
                tick();
                nack += level_up_ack;
                total++; if (obs !== exp_vec) $display("FAIL rstpend_after f%0d c%0d got %h want %h", f, c, obs, exp_vec); else passed++;
            end
        total++; if (nack !== 0) $display("FAIL rstpend_noack got %0d acks want 0", nack); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset(); running = 1; frame_start = 1;
        for (int c = 0; c < 14; c++) begin
            level_up_req = (c == 6) ? 1'b1 : level_up_req;
            tick();
            if (level_up_ack) level_up_req = 0;
            total++; if (obs !== exp_vec) $display("FAIL b2b c%0d got %h want %h", c, obs, exp_vec); else passed++;
        end
        frame_start = 0;
    endtask

    task automatic test_random();
        do_reset(); running = 1;
        for (int c = 0; c < 3000; c++) begin
            frame_start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) running = ~running;
            if (!level_up_req && $urandom_range(0, 29) == 0) level_up_req = 1;
            tick();
            if (level_up_ack) level_up_req = 0;
            total++; if (obs !== exp_vec) $display("FAIL random c%0d got %h want %h", c, obs, exp_vec); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_periodic();
        test_level_up_mid();
        test_wrap_coincident();
        test_running_drop();
        test_reset_pending();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/colour_sequencer.md
# colour_sequencer

Frame-rate scheduler for the colour/drawing pixel stage. It generates the single-cycle `alternate` (background segment flip) and `change_colours` (new random scheme) strobes on frame boundaries: periodically while the game runs, on demand via a level-up request/acknowledge handshake, and once at game start. It sits between the game-state logic and the pixel colouring stage, so that colour events never land mid-frame.

## Interface
- `FLIP_FRAMES`, default 30: number of frames between `alternate` pulses; legal range 2..1023.
- `SCHEME_FRAMES`, default 600: number of frames between automatic `change_colours` pulses; legal range 2..1023.
- `clk`  in  1  system pixel clock; the block's only clock.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `frame_start`  in  1  one-cycle pulse at the start of vertical blanking.
- `running`  in  1  level; high while the game is active.
- `level_up_req`  in  1  request for an immediate scheme change; held high until acknowledged.
- `level_up_ack`  out  1  one-cycle acknowledge.
- `alternate`  out  1  one-cycle pulse that toggles the background flip.
- `change_colours`  out  1  one-cycle pulse that loads a new scheme.
- `phase`  out  10  current flip counter value, for debug and overlay.

## Operation
- Reset: state is IDLE. All outputs are 0. Counters are 0. The pending flag is 0.
- The `pending` flag is set by `level_up_req` while `level_up_ack` is low. It is cleared in the cycle ack is issued.
- State IDLE:
  - Both counters are held at 0.
  - No `alternate` or `change_colours` pulses are produced.
  - When a `frame_start` arrives with `running`=1, go to START.
- State START:
  - Handles exactly one `frame_start`.
  - At that `frame_start`, pulse `change_colours`.
  - If `pending` is set, also pulse `level_up_ack` in the same cycle.
  - Go to RUN. Counters remain 0.
- State RUN, on each `frame_start`:
  - flip_cnt advances modulo `FLIP_FRAMES`. On the wrap to 0, pulse `alternate`.
  - scheme_cnt advances modulo `SCHEME_FRAMES`. On the wrap to 0, pulse `change_colours`.
  - If `pending` is set, pulse `change_colours` and `level_up_ack`, and force scheme_cnt to 0.
  - If a wrap and `pending` occur in the same frame, issue a single `change_colours` pulse and a single ack. scheme_cnt ends at 0.
- `running`=0 in any state:
  - Go to IDLE in the next cycle. Counters are cleared.
  - `running` low takes priority over a coincident `frame_start`; no pulses are issued for that frame.
  - `pending` is preserved across IDLE and serviced in START.
- Handshake:
  - The requester drops `level_up_req` in the cycle after it sees ack.
  - If req is still high in the cycle after ack, it is treated as a new request.
  - Requests that arrive while a request is already pending are merged into it.
- `phase` equals flip_cnt.
- Counters are 10 bits, unsigned. Wrap is compared against `PERIOD-1`; there is no overflow path.

## Timing
- Every output pulse is registered. It is high exactly in the cycle after the `frame_start` cycle that caused it, and lasts one cycle.
- Each of `alternate` and `change_colours` pulses at most once per frame.
- `pending` is set in the cycle after `level_up_req` is sampled.
- A request sampled in the `frame_start` cycle itself is serviced at the next frame.
- Worst-case ack latency is one frame plus 2 cycles.
- Asserting reset mid-frame or mid-handshake clears everything immediately; the pending request is lost, and the requester must re-raise it.
- Back-to-back `frame_start` on consecutive cycles is legal. Each is counted.

## Structure
- Shared package `colour_pkg` contains:
  - State encoding (IDLE=0, START=1, RUN=2).
  - Default period constants.
  - Counter width `FRAME_CNT_W`=10.
- Sub-module `frame_divider` (parameter N): a modulo-N counter with enable (`frame_start`), synchronous clear, and a registered wrap pulse. It is instantiated twice, once for flip and once for scheme.
- The top level holds the FSM, the `pending` flag and the output merging.

## Test plan
Tests use `FLIP_FRAMES`=4 and `SCHEME_FRAMES`=10.
- Reset with `running`=1 and 3 frames -> `change_colours` at frame 1 only; no `alternate`; `phase`=0,0,1.
- `running`=1 for 25 frames -> `alternate` at RUN frames 4, 8, 12, 16, 20, 24; `change_colours` at the start frame plus RUN frames 10 and 20; each pulse is 1 cycle wide.
- `level_up_req` raised at RUN frame 3, mid-frame -> at frame 4, `change_colours` and `level_up_ack` are coincident; the next automatic change is at frame 14.
- Request pending in the frame where scheme_cnt wraps (frame 10) -> exactly one `change_colours` pulse and one ack; scheme_cnt=0.
- `running` dropped in the same cycle as `frame_start` -> no pulses; IDLE next cycle; `phase`=0. A request raised in IDLE is acked together with the START `change_colours` after `running` returns.
- Reset asserted while req is pending -> all outputs go to 0 asynchronously; no ack after release until req is re-raised.
